// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial LSB-first subtractor/comparator built from one full-subtract slice.
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clear,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Difference,
    output logic             Borrow,
    output logic             a_lt_b,
    output logic             a_eq_b,
    output logic             a_gt_b
);
    localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] sa, sb, sd, sd_nx;
    logic [CW-1:0] cnt;
    logic br, d, br_nx, go, step, last;
    always_comb begin
        d = sa[0] ^ sb[0] ^ br;
        br_nx = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
        sd_nx = sd >> 1;
        sd_nx[WIDTH-1] = d;
        go = (state != RUN) & start & ~clear;
        step = (state == RUN) & ~clear;
        last = step & (cnt == CW'(WIDTH - 1));
        state_nx = go ? RUN : (step & ~last) ? RUN : last ? DONE : IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa <= '0;
            sb <= '0;
            sd <= '0;
            br <= 1'b0;
            cnt <= '0;
            Difference <= '0;
            Borrow <= 1'b0;
        end else if (go) begin
            sa <= A;
            sb <= B;
            sd <= '0;
            br <= 1'b0;
            cnt <= '0;
        end else if (step) begin
            sa <= sa >> 1;
            sb <= sb >> 1;
            sd <= sd_nx;
            br <= br_nx;
            cnt <= cnt + 1'b1;
            if (last) begin
                Difference <= sd_nx;
                Borrow <= br_nx;
            end
        end
    end
    assign busy = state == RUN;
    assign done = state == DONE;
    assign a_lt_b = Borrow;
    assign a_eq_b = ~|Difference & ~Borrow;
    assign a_gt_b = ~a_lt_b & ~a_eq_b;
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb_serial_sub_ctrl: table-driven and scoreboard checks of serial_sub_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_sub_ctrl;
    typedef struct packed {
        logic [7:0] d;
        logic bw, lt, eq, gt;
    } exp_t;
    typedef struct packed {
        logic [7:0] a, b;
        exp_t e;
    } vec_t;

    logic clk = 0, rst_n = 0, start = 0, clear = 0;
    logic [7:0] A = 0, B = 0, Difference;
    logic busy, done, Borrow, a_lt_b, a_eq_b, a_gt_b;
    logic start1 = 0, clear1 = 0;
    logic [0:0] a1 = 0, b1 = 0, d1;
    logic busy1, done1, bw1, lt1, eq1, gt1;
    int checks = 0, errors = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    serial_sub_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .A(A), .B(B),
        .busy(busy), .done(done), .Difference(Difference), .Borrow(Borrow),
        .a_lt_b(a_lt_b), .a_eq_b(a_eq_b), .a_gt_b(a_gt_b)
    );
    serial_sub_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .clear(clear1), .A(a1), .B(b1),
        .busy(busy1), .done(done1), .Difference(d1), .Borrow(bw1),
        .a_lt_b(lt1), .a_eq_b(eq1), .a_gt_b(gt1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("diff", Difference, e.d);
                chk("borrow", Borrow, e.bw);
                chk("lt", a_lt_b, e.lt);
                chk("eq", a_eq_b, e.eq);
                chk("gt", a_gt_b, e.gt);
            end
        end
    end

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        e.d = a - b;
        e.bw = a < b;
        e.lt = a < b;
        e.eq = a == b;
        e.gt = a > b;
        return e;
    endfunction

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input exp_t e);
        int n;
        bit seen;
        @(negedge clk);
        A = a; B = b; start = 1;
        q.push_back(e);
        @(negedge clk);
        start = 0; A = 8'($urandom); B = 8'($urandom);
        n = 0; seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (done) seen = 1;
            else begin
                if (busy) n++;
                @(negedge clk);
            end
        end
        chk("done_seen", seen, 1);
        chk("busy_cycles", n, 8);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[8];
        logic [4:0] exp1[4];
        tbl[0] = '{8'h5A, 8'h3C, '{8'h1E, 1'b0, 1'b0, 1'b0, 1'b1}};
        tbl[1] = '{8'h3C, 8'h5A, '{8'hE2, 1'b1, 1'b1, 1'b0, 1'b0}};
        tbl[2] = '{8'h77, 8'h77, '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0}};
        tbl[3] = '{8'h00, 8'h01, '{8'hFF, 1'b1, 1'b1, 1'b0, 1'b0}};
        tbl[4] = '{8'h80, 8'h7F, '{8'h01, 1'b0, 1'b0, 1'b0, 1'b1}};
        tbl[5] = '{8'h7F, 8'h80, '{8'hFF, 1'b1, 1'b1, 1'b0, 1'b0}};
        tbl[6] = '{8'hFF, 8'h00, '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b1}};
        tbl[7] = '{8'h00, 8'h00, '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0}};
        exp1 = '{5'b00010, 5'b11100, 5'b10001, 5'b00010};

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_diff", Difference, 0);
        chk("rst_borrow", Borrow, 0);
        chk("rst_eq", a_eq_b, 1);
        chk("rst_lt", a_lt_b, 0);
        chk("rst_gt", a_gt_b, 0);
        rst_n = 1;

        for (int i = 0; i < 8; i++) run_op(tbl[i].a, tbl[i].b, tbl[i].e);
        for (int i = 0; i < 6; i++) begin
            logic [7:0] a, b;
            a = 8'($urandom); b = 8'($urandom);
            run_op(a, b, model(a, b));
        end

        // start held high: accepts at edges 0, 9, 18; released before edge 27
        @(negedge clk);
        A = 8'h10; B = 8'h01; start = 1;
        repeat (3) q.push_back('{8'h0F, 1'b0, 1'b0, 1'b0, 1'b1});
        for (int e = 0; e < 27; e++) begin
            @(negedge clk);
            chk("b2b_done", done, (e % 9) == 8);
            if (e % 9 < 7) begin A = 8'($urandom); B = 8'($urandom); end
            else if (e % 9 == 7) begin A = 8'h10; B = 8'h01; end
            if (e == 26) start = 0;
        end
        repeat (12) @(negedge clk);
        chk("b2b_idle", busy, 0);

        run_op(8'h5A, 8'h3C, tbl[0].e);
        @(negedge clk);
        A = 8'h01; B = 8'h02; start = 1;
        repeat (3) begin @(negedge clk); start = 0; end
        clear = 1;
        @(negedge clk);
        clear = 0;
        chk("clear_busy", busy, 0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("clear_nodone", done, 0);
        end
        chk("clear_diff", Difference, 8'h1E);
        chk("clear_borrow", Borrow, 0);

        @(negedge clk);
        start = 1; clear = 1;
        @(negedge clk);
        start = 0; clear = 0;
        chk("clear_wins", busy, 0);

        @(negedge clk);
        A = 8'h12; B = 8'h34; start = 1;
        @(negedge clk);
        start = 0;
        repeat (3) @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_diff", Difference, 0);
        chk("arst_borrow", Borrow, 0);
        chk("arst_eq", a_eq_b, 1);
        @(negedge clk);
        rst_n = 1;
        run_op(8'hFF, 8'h01, model(8'hFF, 8'h01));

        for (int i = 0; i < 4; i++) begin
            logic [1:0] ab;
            ab = 2'(i);
            @(negedge clk);
            a1 = ab[1]; b1 = ab[0]; start1 = 1;
            @(negedge clk);
            start1 = 0; a1 = ~a1; b1 = ~b1;
            chk("w1_busy", busy1, 1);
            chk("w1_nodone", done1, 0);
            @(negedge clk);
            chk("w1_done", done1, 1);
            chk("w1_diff", d1, exp1[i][4]);
            chk("w1_borrow", bw1, exp1[i][3]);
            chk("w1_lt", lt1, exp1[i][2]);
            chk("w1_eq", eq1, exp1[i][1]);
            chk("w1_gt", gt1, exp1[i][0]);
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
- Bit-serial subtract/compare sequencer for the subtractor/comparator datapath.
- Loads two WIDTH-bit operands and steps a one-bit full-subtract cell (two half-subtract stages plus a borrow register) LSB-first, one bit per clock.
- Returns the registered Difference, the final Borrow and magnitude-compare flags.
- Gives area-constrained users an N-bit subtractor/comparator built from one bit-slice.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled only when busy=0.
- clear  input  1  synchronous abort; priority over start.
- A  input  WIDTH  minuend, captured on the accepted start edge.
- B  input  WIDTH  subtrahend, captured on the accepted start edge.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse; results updated this cycle.
- Difference  output  WIDTH  (A - B) mod 2^WIDTH, held until the next completion.
- Borrow  output  1  final borrow out of the MSB (1 iff A < B unsigned).
- a_lt_b  output  1  equals Borrow.
- a_eq_b  output  1  Difference == 0 and Borrow == 0.
- a_gt_b  output  1  ~a_lt_b & ~a_eq_b.

Behaviour:
- Reset (rst_n=0, asynchronous) forces:
  - state IDLE; busy=0, done=0.
  - Difference=0, Borrow=0, a_lt_b=0, a_eq_b=1, a_gt_b=0.
  - All internal shift registers, borrow register and counter = 0.
- Reset deasserts synchronously to clk.
- State IDLE (busy=0, done=0):
  - clear=1: stay IDLE.
  - start=1: load A and B into shift regs sa and sb, borrow reg br=0, bit counter cnt=0; go to RUN.
- State RUN (busy=1, done=0), each edge:
  - d = sa[0]^sb[0]^br.
  - br <= (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&br).
  - sa and sb shift right 1; d shifts into the MSB of internal shift reg sd (sd shifts right); cnt <= cnt+1.
  - On the edge where cnt == WIDTH-1: copy the final sd into Difference, the final br into Borrow and the flags; go to DONE.
  - start is ignored while in RUN.
  - clear=1 in RUN: go to IDLE next edge. Difference, Borrow and flags keep the last completed result; no done pulse.
- State DONE (busy=0, done=1 for exactly one cycle):
  - start=1 (and clear=0) is accepted as in IDLE and goes to RUN: back-to-back operation.
  - Otherwise go to IDLE.
- Latency:
  - Call the edge that samples start edge 0. Bit i is computed at edge i+1.
  - done is high during the cycle after edge WIDTH.
  - Minimum issue interval is WIDTH+1 cycles.
- Width rules:
  - cnt width = max(1, $clog2(WIDTH)).
  - Difference is mod 2^WIDTH, unsigned compare.
  - WIDTH=1 must work (RUN lasts one edge).
- Result outputs change only on the DONE transition or on reset.
  - A and B changing after the accepted start have no effect.
- clear and start together in IDLE or DONE: clear wins; stay in or go to IDLE.
- rst_n asserted mid-RUN: immediate reset values; the operation is lost.

Test Plan:
- WIDTH=8, A=0x5A, B=0x3C, start pulse -> busy high 8 cycles, then done pulse. Difference=0x1E, Borrow=0, a_gt_b=1.
- A=0x3C, B=0x5A -> Difference=0xE2, Borrow=1, a_lt_b=1. Then A=0x77, B=0x77 -> Difference=0x00, a_eq_b=1. Then A=0x00, B=0x01 -> Difference=0xFF, Borrow=1.
- Hold start=1 continuously with A=0x10, B=0x01 -> done pulses every 9 cycles, each with Difference=0x0F. start and operand changes during busy are ignored.
- Complete A=0x5A, B=0x3C, then start A=0x01, B=0x02 and assert clear at cycle 4 -> IDLE next edge, no done pulse, Difference stays 0x1E.
- Assert rst_n=0 mid-RUN, asynchronously between edges -> outputs immediately busy=0, done=0, Difference=0, a_eq_b=1. After release, a new op A=0xFF, B=0x01 yields 0xFE.
- WIDTH=1 build: all four (A,B) combinations -> (0,0)->D0 Bw0 eq; (0,1)->D1 Bw1 lt; (1,0)->D1 Bw0 gt; (1,1)->D0 Bw0 eq. done appears 1 cycle after start.
